imem_boot_loader: RTL

//  Writer side of the instruction-memory load port. Receives a byte stream over a valid/ready handshake,

---
 rtl/imem_boot_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream loader for the instruction memory: takes a length-prefixed little-endian frame,
// writes the words from BASE_ADDR upward and keeps the core in reset until the program is written.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        reload,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned RW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERROR} state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;
  logic [RW-1:0]   remaining;
  logic [31:0]     assembled;
  logic            xfer;

  assign xfer      = s_valid && s_ready;
  // The 4th byte is used straight from the bus, so only the low three lanes need storage.
  assign assembled = {s_data, word_buf};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HDR;
      byte_idx  <= 2'd0;
      word_buf  <= 24'd0;
      remaining <= '0;
      s_ready   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= BASE_ADDR;
      wr_data   <= 32'd0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        HDR, DATA: begin
          s_ready <= 1'b1;
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_buf[7:0]   <= s_data;
              2'd1:    word_buf[15:8]  <= s_data;
              2'd2:    word_buf[23:16] <= s_data;
              default: ;
            endcase
            if (byte_idx == 2'd3) begin
              if (state == HDR) begin
                if (assembled == 32'd0) begin
                  state     <= DONE;
                  s_ready   <= 1'b0;
                  core_hold <= 1'b0;
                  done      <= 1'b1;
                end else if (assembled > 32'(MAX_WORDS)) begin
                  state   <= ERROR;
                  s_ready <= 1'b0;
                  error   <= 1'b1;
                end else begin
                  remaining <= assembled[RW-1:0];
                  state     <= DATA;
                end
              end else begin
                wr_data <= assembled;
                wr_en   <= 1'b1;
                s_ready <= 1'b0;
                state   <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          wr_addr   <= wr_addr + 32'(ADDR_STEP);
          remaining <= remaining - RW'(1);
          if (remaining == RW'(1)) begin
            state     <= DONE;
            core_hold <= 1'b0;
            done      <= 1'b1;
          end else begin
            state   <= DATA;
            s_ready <= 1'b1;
          end
        end
        DONE: begin
          if (reload) begin
            state     <= HDR;
            byte_idx  <= 2'd0;
            wr_addr   <= BASE_ADDR;
            core_hold <= 1'b1;
            done      <= 1'b0;
            s_ready   <= 1'b1;
          end
        end
        ERROR: begin
          if (reload) begin
            state    <= HDR;
            byte_idx <= 2'd0;
            wr_addr  <= BASE_ADDR;
            error    <= 1'b0;
            s_ready  <= 1'b1;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule
